// File: rtl/dcmi_fifo_ring.sv
// -----------------------------------------------------------------------------
// dcmi_fifo_ring
//
// DEPTH-entry, DW-bit ring buffer between the DCMI pixel packer (write side)
// and the DMA/bus master (read side). It is the parametrised successor to the
// two-entry DCMI ping-pong buffer and uses the same req/rdy handshake on both
// sides. It also reports the fill level, an almost-full watermark and sticky
// overflow/underflow flags for the DMA scheduler.
//
// Parameters
//   DW        data width in bits (1..64)
//   DEPTH     number of entries, power of two (2..64)
//   AFULL_TH  afull asserts when level >= AFULL_TH (1..DEPTH)
//   AW        pointer width, derived from DEPTH (not overridable)
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous, active-high reset
//   block_en  block enable; low clears pointers, level and flags on the next edge
//   wr_rdy    out: a free entry is available
//   wr_req    in : write request
//   wr_data   in : write data
//   rd_rdy    out: a filled entry is available
//   rd_req    in : read request
//   rd_data   out: entry at the read pointer, zero while empty
//   level     out: number of filled entries, 0..DEPTH
//   afull     out: level >= AFULL_TH
//   ovf       out: sticky, set by wr_req while wr_rdy=0
//   udf       out: sticky, set by rd_req while rd_rdy=0
// -----------------------------------------------------------------------------
module dcmi_fifo_ring #(
  parameter  int DW       = 32,
  parameter  int DEPTH    = 4,
  parameter  int AFULL_TH = DEPTH - 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          block_en,
  output logic          wr_rdy,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          rd_rdy,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   level,
  output logic          afull,
  output logic          ovf,
  output logic          udf
);

  // Elaboration-time parameter legality checks.
  if (DW < 1 || DW > 64) begin : g_bad_dw
    $error("dcmi_fifo_ring: DW must be in 1..64");
  end
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dcmi_fifo_ring: DEPTH must be a power of two in 2..64");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_th
    $error("dcmi_fifo_ring: AFULL_TH must be in 1..DEPTH");
  end

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AFTH = (AW+1)'(AFULL_TH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          r_udf;

  logic w_wr_rdy;
  logic w_rd_rdy;
  logic w_wr_vld;
  logic w_rd_vld;

  // Ready flags come only from the registered level, so req never feeds rdy
  // combinationally. Full + both requests therefore accepts only the read,
  // and empty + both requests accepts only the write (no fall-through).
  assign w_wr_rdy = (r_level != LVL_FULL);
  assign w_rd_rdy = (r_level != '0);
  assign w_wr_vld = wr_req & w_wr_rdy;
  assign w_rd_vld = rd_req & w_rd_rdy;

  // Control state: pointers, level and sticky flags. block_en=0 behaves like a
  // synchronous version of rst and overrides all traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (!block_en) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      // Pointers wrap naturally at DEPTH because DEPTH == 2**AW.
      if (w_wr_vld) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_vld) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      unique case ({w_wr_vld, w_rd_vld})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (wr_req && !w_wr_rdy) begin
        r_ovf <= 1'b1;
      end
      if (rd_req && !w_rd_rdy) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Storage has no reset. A write presented while rst is held can land in
  // entry 0, but the pointers stay at zero, so the first accepted write after
  // reset overwrites that entry before rd_rdy can rise.
  always_ff @(posedge clk) begin
    if (block_en && w_wr_vld) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  assign wr_rdy  = w_wr_rdy;
  assign rd_rdy  = w_rd_rdy;
  // Gating hides stale or uninitialised storage while the ring is empty.
  assign rd_data = w_rd_rdy ? r_mem[r_rptr] : '0;
  assign level   = r_level;
  assign afull   = (r_level >= LVL_AFTH);
  assign ovf     = r_ovf;
  assign udf     = r_udf;

endmodule
